// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART blocks.
package uart_pkg;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned UART_OVS_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned ovs);
    int unsigned div;
    div = clk_freq / (baud * ovs);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: wraps every DIV clocks, held at zero while cleared.
module uart_tick_gen #(
  parameter int unsigned DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_clr || r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with 3-tick majority vote per bit.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 1000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = UART_OVS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       donerx,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  , output logic     parity_err
`endif
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVS);
  localparam int unsigned OW       = $clog2(OVS);
  localparam int unsigned BW       = $clog2(DATA_BITS);
  localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_t r_state, w_next;

  logic [1:0]           r_sync;
  logic [1:0]           r_hist;
  logic [OW-1:0]        r_ovs;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [7:0]           r_dout;
  logic                 r_done, r_ferr;
  logic w_rx_s, w_tick, w_mid, w_end, w_vote, w_par_bad;
  logic w_busy, w_take_bit, w_good, w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic r_par, r_perr, w_perr_set;
`endif

  assign w_rx_s = r_sync[1];

  uart_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (r_state == IDLE),
    .o_tick (w_tick)
  );

  // Vote at the 8th tick using that tick's sample and the two before it.
  assign w_mid  = w_tick && (r_ovs == OVS_MID);
  assign w_end  = w_tick && (r_ovs == OVS_LAST);
  assign w_vote = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ^{r_shreg, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_rx_s) w_next = START;
      START:     if (w_mid && w_vote) w_next = IDLE;
                 else if (w_end)      w_next = DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (w_end && r_bitcnt == BIT_LAST) w_next = PARITY;
      PARITY:    if (w_end) w_next = STOP;
`else
      DATA:      if (w_end && r_bitcnt == BIT_LAST) w_next = STOP;
`endif
      STOP:      if (w_mid) w_next = w_vote ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (w_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != IDLE);
    w_take_bit = (r_state == DATA) && w_mid;
    w_good     = (r_state == STOP) && w_mid && w_vote && !w_par_bad;
    w_ferr_set = (r_state == STOP) && w_mid && !w_vote;
`ifdef UART_RX_PARITY_EN
    w_perr_set = (r_state == STOP) && w_mid && w_vote && w_par_bad;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= '1;
      r_hist   <= '1;
      r_ovs    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], rx};
      r_done <= w_good;
      r_ferr <= w_ferr_set;
`ifdef UART_RX_PARITY_EN
      r_perr <= w_perr_set;
      if (r_state == PARITY && w_mid) r_par <= w_vote;
`endif
      if (r_state == IDLE) begin
        r_ovs    <= '0;
        r_bitcnt <= '0;
      end else if (w_tick) begin
        r_hist <= {r_hist[0], w_rx_s};
        r_ovs  <= (r_ovs == OVS_LAST) ? '0 : r_ovs + 1'b1;
        if (r_state == DATA && r_ovs == OVS_LAST) r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_take_bit) r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
      if (w_good)     r_dout  <= r_shreg;
    end
  end

  assign dout      = r_dout;
  assign donerx    = r_done;
  assign frame_err = r_ferr;
  assign busy      = w_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule
